mm_match_unit: RTL

16-entry token matching memory for the CUES FC0 firing-control path, directly upstream of the 16:1 one-hot match-data multiplexer. Each incoming operand token is compared by tag against all stored waiting tokens. On a hit the unit drives a one-hot match vector to the multiplexer, takes the partner operand back from it, frees the entry and emits a fired two-operand token. On a miss the token is stored in the lowest free entry.

---
 rtl/mm_match_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mm_match_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mm_match_unit
//  Brief    : 16-entry tag-matching memory for operand token firing control.
//  Revision : 1.0 - initial release
// ============================================================================
module mm_match_unit #(
    parameter int TAG_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 in_lr,
    input  logic [DATA_W-1:0]    in_data,
    output logic [15:0]          mmc_mtch_rslt,
    output logic [16*DATA_W-1:0] mmc_data_all,
    input  logic [DATA_W-1:0]    mmc_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TAG_W-1:0]     out_tag,
    output logic [DATA_W-1:0]    out_ldata,
    output logic [DATA_W-1:0]    out_rdata,
    output logic [4:0]           occupancy,
    output logic                 ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_RSLT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              w_in_ready;

    logic [TAG_W-1:0]  r_in_tag;
    logic              r_in_lr;
    logic [DATA_W-1:0] r_in_data;

    logic [15:0]       r_valid;
    logic [15:0]       r_mtch;
    logic [15:0]       w_raw_hit;
    logic [15:0]       w_hit_oh;
    logic [15:0]       w_free_oh;
    logic              w_free_any;
    logic              w_hit;
    logic              w_accept;
    logic              w_miss_wr;

    logic              r_out_valid;
    logic [TAG_W-1:0]  r_out_tag;
    logic [DATA_W-1:0] r_out_ldata;
    logic [DATA_W-1:0] r_out_rdata;
    logic [4:0]        r_occ;
    logic              r_ovf;

    assign w_accept   = in_valid && w_in_ready;
    assign w_hit      = |r_mtch;
    assign w_free_any = ~&r_valid;
    assign w_miss_wr  = (r_state == S_RSLT) && !w_hit && w_free_any;

    // Lowest-index priority for both the hit vector and the free-slot pick.
    always_comb begin
        w_hit_oh  = '0;
        w_free_oh = '0;
        for (int i = 15; i >= 0; i--) begin
            if (w_raw_hit[i]) begin
                w_hit_oh    = '0;
                w_hit_oh[i] = 1'b1;
            end
            if (!r_valid[i]) begin
                w_free_oh    = '0;
                w_free_oh[i] = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_entry
            logic [TAG_W-1:0]  r_tag;
            logic              r_lr;
            logic [DATA_W-1:0] r_data;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_tag  <= '0;
                    r_lr   <= 1'b0;
                    r_data <= '0;
                end else if (w_miss_wr && w_free_oh[gi]) begin
                    r_tag  <= r_in_tag;
                    r_lr   <= r_in_lr;
                    r_data <= r_in_data;
                end
            end

            assign w_raw_hit[gi] = r_valid[gi] && (r_tag == r_in_tag) && (r_lr != r_in_lr);
            assign mmc_data_all[DATA_W*gi +: DATA_W] = r_data;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next_state = S_CMP;
            end
            S_CMP:  w_next_state = S_RSLT;
            S_RSLT: w_next_state = w_hit ? S_OUT : S_IDLE;
            S_OUT:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_tag    <= '0;
            r_in_lr     <= 1'b0;
            r_in_data   <= '0;
            r_valid     <= '0;
            r_mtch      <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_ldata <= '0;
            r_out_rdata <= '0;
            r_occ       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_in_tag  <= in_tag;
                r_in_lr   <= in_lr;
                r_in_data <= in_data;
            end

            // Vector is only live for the single RSLT cycle that follows CMP.
            r_mtch <= (r_state == S_CMP) ? w_hit_oh : 16'h0000;

            if (r_state == S_RSLT) begin
                if (w_hit) begin
                    r_out_tag   <= r_in_tag;
                    r_out_ldata <= r_in_lr ? mmc_data : r_in_data;
                    r_out_rdata <= r_in_lr ? r_in_data : mmc_data;
                    r_out_valid <= 1'b1;
                    r_valid     <= r_valid & ~r_mtch;
                    r_occ       <= r_occ - 5'd1;
                end else if (w_free_any) begin
                    r_valid <= r_valid | w_free_oh;
                    r_occ   <= r_occ + 5'd1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end

            if ((r_state == S_OUT) && out_ready) r_out_valid <= 1'b0;
        end
    end

    assign in_ready      = w_in_ready;
    assign mmc_mtch_rslt = r_mtch;
    assign out_valid     = r_out_valid;
    assign out_tag       = r_out_tag;
    assign out_ldata     = r_out_ldata;
    assign out_rdata     = r_out_rdata;
    assign occupancy     = r_occ;
    assign ovf           = r_ovf;

endmodule
`default_nettype wire
